// File: rtl/crc16_pkg.sv
// Shared constants, FSM state encoding and the single-bit CRC-16/CCITT step
// used by the frame controller and its serial engine.
package crc16_pkg;

   localparam logic [15:0] CRC_POLY         = 16'h1021;
   localparam logic [15:0] CRC_INIT_DEFAULT = 16'hFFFF;
   localparam int          BYTE_W           = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   // One LFSR step: feedback is the outgoing MSB xor the incoming bit.
   function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic u);
      logic fb;
      fb = crc[15] ^ u;
      return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/crc16_frame_ctrl_if.sv
// Byte stream into the frame controller.
// Handshake: a byte transfers on every rising edge where in_valid and
// in_ready are both 1. While in_valid is 1 and the byte has not transferred,
// the source holds in_data and in_last stable. in_ready never depends on
// in_valid. in_last marks the final byte of a frame.
interface crc16_frame_ctrl_if;
   import crc16_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [BYTE_W-1:0] in_data;
   logic              in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/crc16_serial_engine.sv
// Bit-serial CRC-16/CCITT (x^16+x^12+x^5+1) register. init loads CRC_INIT,
// compute_enable shifts in one message bit u per clock.
module crc16_serial_engine
   import crc16_pkg::*;
#(
   parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        init,
   input  logic        compute_enable,
   input  logic        u,
   output logic [15:0] crc_out
);

   // CRC register: reset clears, init has priority over a shift.
   always_ff @(posedge clock) begin
      if (reset) begin
         crc_out <= 16'h0000;
      end else if (init) begin
         crc_out <= CRC_INIT;
      end else if (compute_enable) begin
         crc_out <= crc_step(crc_out, u);
      end
   end

endmodule

// File: rtl/crc16_frame_ctrl.sv
// Frame controller: accepts bytes from a valid/ready stream and feeds them
// MSB-first into one serial CRC engine. At frame end it pulses done with the
// CRC (generate mode) or the residue check result (check mode).
module crc16_frame_ctrl
   import crc16_pkg::*;
#(
   parameter logic [15:0] CRC_INIT = CRC_INIT_DEFAULT,
   parameter int          MAX_LEN  = 1024,
   parameter int          LEN_W    = 11
) (
   input  logic                 clock,
   input  logic                 reset,
   crc16_frame_ctrl_if.slave    byte_if,
   input  logic                 mode,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          crc_out,
   output logic                 crc_ok,
   output logic                 len_err,
   output logic [LEN_W-1:0]     byte_count,
   output state_t               fsm_state
);

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

   state_t            state, state_nxt;
   logic              mode_q;
   logic              last_q;
   logic [BYTE_W-1:0] shreg;
   logic [2:0]        bit_cnt;
   logic              crc_ok_q;
   logic              len_err_q;
   logic              eng_init;
   logic              eng_en;
   logic              ready;
   logic              at_max;
   logic              ok_now;
   logic              len_now;

   crc16_serial_engine #(
      .CRC_INIT(CRC_INIT)
   ) u_engine (
      .clock          (clock),
      .reset          (reset),
      .init           (eng_init),
      .compute_enable (eng_en),
      .u              (shreg[BYTE_W-1]),
      .crc_out        (crc_out)
   );

   assign at_max  = (byte_count == MAX_CNT);
   assign ok_now  = mode_q && (crc_out == 16'h0000);
   assign len_now = at_max && !last_q;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and engine controls; engine is idle outside INIT/SHIFT.
   always_comb begin
      state_nxt = state;
      eng_init  = 1'b0;
      eng_en    = 1'b0;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            if (byte_if.in_valid) state_nxt = INIT;
         end
         INIT: begin
            eng_init  = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            ready = 1'b1;
            if (byte_if.in_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            eng_en = 1'b1;
            if (bit_cnt == 3'd0) state_nxt = (last_q || at_max) ? DONE : LOAD;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Frame datapath: mode latch, byte capture, bit shifting and result hold.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q     <= 1'b0;
         last_q     <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= 3'd0;
         byte_count <= '0;
         crc_ok_q   <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (byte_if.in_valid) begin
                  mode_q     <= mode;
                  last_q     <= 1'b0;
                  byte_count <= '0;
                  crc_ok_q   <= 1'b0;
                  len_err_q  <= 1'b0;
               end
            end
            LOAD: begin
               if (byte_if.in_valid) begin
                  shreg      <= byte_if.in_data;
                  last_q     <= byte_if.in_last;
                  byte_count <= byte_count + 1'b1;
                  bit_cnt    <= 3'd7;
               end
            end
            SHIFT: begin
               shreg   <= {shreg[BYTE_W-2:0], 1'b0};
               bit_cnt <= bit_cnt - 1'b1;
            end
            DONE: begin
               crc_ok_q  <= ok_now;
               len_err_q <= len_now;
            end
            default: begin
            end
         endcase
      end
   end

   // Results are live during DONE and held afterwards until the next frame.
   always_comb begin
      byte_if.in_ready = ready;
      busy             = (state != IDLE);
      done             = (state == DONE);
      crc_ok           = done ? ok_now  : crc_ok_q;
      len_err          = done ? len_now : len_err_q;
      fsm_state        = state;
   end

endmodule

// File: tb/tb_crc16_frame_ctrl.sv
// Directed bench for crc16_frame_ctrl: a table of frames with hand-computed
// results, plus hand-written sequences for length overflow and mid-frame reset.
module tb_crc16_frame_ctrl;
   import crc16_pkg::*;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;
   int   cyc;

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- stimulus and DUTs ----------------
   logic       sel;
   logic       drv_valid;
   logic [7:0] drv_data;
   logic       drv_last;
   logic       drv_mode;

   crc16_frame_ctrl_if if_a ();
   crc16_frame_ctrl_if if_b ();

   assign if_a.in_valid = drv_valid & ~sel;
   assign if_a.in_data  = drv_data;
   assign if_a.in_last  = drv_last;
   assign if_b.in_valid = drv_valid & sel;
   assign if_b.in_data  = drv_data;
   assign if_b.in_last  = drv_last;

   logic        a_busy, a_done, a_ok, a_len;
   logic [15:0] a_crc;
   logic [10:0] a_cnt;
   state_t      a_state;
   logic        b_busy, b_done, b_ok, b_len;
   logic [15:0] b_crc;
   logic [2:0]  b_cnt;
   state_t      b_state;

   crc16_frame_ctrl #(.CRC_INIT(16'hFFFF), .MAX_LEN(1024), .LEN_W(11)) dut_a (
      .clock(clock), .reset(reset), .byte_if(if_a), .mode(drv_mode),
      .busy(a_busy), .done(a_done), .crc_out(a_crc), .crc_ok(a_ok),
      .len_err(a_len), .byte_count(a_cnt), .fsm_state(a_state)
   );

   crc16_frame_ctrl #(.CRC_INIT(16'hFFFF), .MAX_LEN(4), .LEN_W(3)) dut_b (
      .clock(clock), .reset(reset), .byte_if(if_b), .mode(drv_mode),
      .busy(b_busy), .done(b_done), .crc_out(b_crc), .crc_ok(b_ok),
      .len_err(b_len), .byte_count(b_cnt), .fsm_state(b_state)
   );

   logic        r_valid, r_ready, r_busy, r_done, r_ok, r_len;
   logic [15:0] r_crc;
   logic [10:0] r_cnt;
   assign r_valid = sel ? if_b.in_valid : if_a.in_valid;
   assign r_ready = sel ? if_b.in_ready : if_a.in_ready;
   assign r_busy  = sel ? b_busy : a_busy;
   assign r_done  = sel ? b_done : a_done;
   assign r_ok    = sel ? b_ok   : a_ok;
   assign r_len   = sel ? b_len  : a_len;
   assign r_crc   = sel ? b_crc  : a_crc;
   assign r_cnt   = sel ? {8'b0, b_cnt} : a_cnt;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [15:0] crc;
      bit          chk_crc;
      bit          ok;
      bit          len;
      int          cnt;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks;
   int   failures;
   int   start_cyc;
   int   acc_cnt;
   int   since_acc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic fail_timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=timeout expected=event (cycle %0d)", nm, cyc);
   endtask

   // Monitor: handshake spacing, idle ready, and done results against exp_q.
   always @(negedge clock) begin
      if (reset) begin
         since_acc = 100;
      end else begin
         if (r_ready) chk("ready_after_shift", 32'(since_acc >= 8), 32'd1);
         if (!r_busy) chk("ready_when_idle", 32'(r_ready), 32'd0);
         if (r_valid && r_ready) begin
            since_acc = 0;
            acc_cnt++;
         end else if (since_acc < 100) begin
            since_acc++;
         end
         if (r_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.chk_crc) chk("crc_out", 32'(r_crc), 32'(mon_e.crc));
               chk("crc_ok", 32'(r_ok), 32'(mon_e.ok));
               chk("len_err", 32'(r_len), 32'(mon_e.len));
               chk("byte_count", 32'(r_cnt), 32'(mon_e.cnt));
               if (mon_e.lat >= 0) chk("done_latency", 32'(cyc - start_cyc), 32'(mon_e.lat));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [7:0] frm[16];
   bit         lst[16];

   task automatic wait_accept();
      bit got;
      int t;
      got = 1'b0;
      t   = 0;
      while (!got && t < 300) begin
         @(negedge clock);
         if (r_valid && r_ready) got = 1'b1;
         else t++;
      end
      if (!got) fail_timeout("accept");
      @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input int n, input bit m, input int gap, input bit flip);
      drv_mode = m;
      for (int i = 0; i < n; i++) begin
         if (gap > 0) begin
            int g;
            g = $urandom_range(0, gap);
            drv_valid = 1'b0;
            repeat (g) @(posedge clock);
            #1;
         end
         if (i == 0) start_cyc = cyc;
         drv_valid = 1'b1;
         drv_data  = frm[i];
         drv_last  = lst[i];
         wait_accept();
         if (flip && i == 0) drv_mode = ~m;
      end
      drv_valid = 1'b0;
      drv_last  = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (exp_q.size() > 0 && t < 3000) begin
         @(negedge clock);
         t++;
      end
      if (exp_q.size() > 0) begin
         fail_timeout("done");
         exp_q.delete();
      end
      @(posedge clock);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int          n;
      bit          m;
      int          gap;
      bit          flip;
      logic [7:0]  d[16];
      logic [15:0] crc;
      bit          ok;
      int          lat;
   } vec_t;

   localparam int NV = 6;
   vec_t tbl[NV];
   exp_t e;

   initial begin
      sel       = 1'b0;
      drv_valid = 1'b0;
      drv_data  = 8'h00;
      drv_last  = 1'b0;
      drv_mode  = 1'b0;
      checks    = 0;
      failures  = 0;
      acc_cnt   = 0;
      start_cyc = 0;
      since_acc = 100;

      // Rows 1-4 carry "123456789"; check rows append the CRC bytes.
      for (int r = 0; r < NV; r++) begin
         for (int j = 0; j < 16; j++) tbl[r].d[j] = 8'h00;
         for (int j = 0; j < 9; j++) tbl[r].d[j] = 8'h31 + 8'(j);
         tbl[r].gap  = 0;
         tbl[r].flip = 1'b0;
      end
      tbl[0].n = 1;  tbl[0].m = 1'b0; tbl[0].d[0] = 8'h00;
      tbl[0].crc = 16'hE1F0; tbl[0].ok = 1'b0; tbl[0].lat = 11;
      tbl[1].n = 9;  tbl[1].m = 1'b0;
      tbl[1].crc = 16'h29B1; tbl[1].ok = 1'b0; tbl[1].lat = 83;
      tbl[2].n = 11; tbl[2].m = 1'b1; tbl[2].flip = 1'b1;
      tbl[2].d[9] = 8'h29; tbl[2].d[10] = 8'hB1;
      tbl[2].crc = 16'h0000; tbl[2].ok = 1'b1; tbl[2].lat = 101;
      // A flipped final bit leaves exactly the polynomial as residue.
      tbl[3].n = 11; tbl[3].m = 1'b1;
      tbl[3].d[9] = 8'h29; tbl[3].d[10] = 8'hB0;
      tbl[3].crc = 16'h1021; tbl[3].ok = 1'b0; tbl[3].lat = 101;
      tbl[4].n = 9;  tbl[4].m = 1'b0; tbl[4].gap = 5;
      tbl[4].crc = 16'h29B1; tbl[4].ok = 1'b0; tbl[4].lat = -1;
      tbl[5].n = 3;  tbl[5].m = 1'b1;
      tbl[5].d[0] = 8'h00; tbl[5].d[1] = 8'hE1; tbl[5].d[2] = 8'hF0;
      tbl[5].crc = 16'h0000; tbl[5].ok = 1'b1; tbl[5].lat = 29;

      // Reset and reset-value checks on both instances.
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_in_ready", 32'(if_a.in_ready), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_crc_out", 32'(a_crc), 32'd0);
      chk("rst_crc_ok", 32'(a_ok), 32'd0);
      chk("rst_len_err", 32'(a_len), 32'd0);
      chk("rst_byte_count", 32'(a_cnt), 32'd0);
      chk("rst_b_crc_out", 32'(b_crc), 32'd0);
      chk("rst_b_busy", 32'(b_busy), 32'd0);
      @(posedge clock);
      #1;

      // Table-driven frames.
      for (int r = 0; r < NV; r++) begin
         for (int j = 0; j < 16; j++) begin
            frm[j] = tbl[r].d[j];
            lst[j] = (j == tbl[r].n - 1);
         end
         e.crc = tbl[r].crc; e.chk_crc = 1'b1; e.ok = tbl[r].ok; e.len = 1'b0;
         e.cnt = tbl[r].n;   e.lat = tbl[r].lat;
         exp_q.push_back(e);
         acc_cnt = 0;
         send_frame(tbl[r].n, tbl[r].m, tbl[r].gap, tbl[r].flip);
         wait_done();
         chk("accepted_bytes", 32'(acc_cnt), 32'(tbl[r].n));
         chk("held_crc_ok", 32'(r_ok), 32'(tbl[r].ok));
         chk("held_byte_count", 32'(r_cnt), 32'(tbl[r].n));
         chk("idle_busy", 32'(r_busy), 32'd0);
      end

      // MAX_LEN = 4 instance: 6 bytes, in_last only on byte 6.
      sel = 1'b1;
      for (int j = 0; j < 6; j++) begin
         frm[j] = 8'h31 + 8'(j);
         lst[j] = (j == 5);
      end
      e.crc = 16'h0000; e.chk_crc = 1'b0; e.ok = 1'b0; e.len = 1'b1; e.cnt = 4; e.lat = 38;
      exp_q.push_back(e);
      e.len = 1'b0; e.cnt = 2; e.lat = -1;
      exp_q.push_back(e);
      acc_cnt = 0;
      send_frame(6, 1'b0, 0, 1'b0);
      wait_done();
      chk("len_accepted_bytes", 32'(acc_cnt), 32'd6);
      chk("len_held_len_err", 32'(r_len), 32'd0);
      chk("len_held_byte_count", 32'(r_cnt), 32'd2);
      sel = 1'b0;
      @(posedge clock);
      #1;

      // Reset during SHIFT of byte 3, then a clean frame.
      for (int j = 0; j < 9; j++) begin
         frm[j] = 8'h31 + 8'(j);
         lst[j] = 1'b0;
      end
      send_frame(3, 1'b1, 0, 1'b0);
      repeat (2) @(posedge clock);
      #1;
      chk("pre_rst_busy", 32'(a_busy), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midrst_busy", 32'(a_busy), 32'd0);
      chk("midrst_in_ready", 32'(if_a.in_ready), 32'd0);
      chk("midrst_done", 32'(a_done), 32'd0);
      chk("midrst_crc_out", 32'(a_crc), 32'd0);
      chk("midrst_crc_ok", 32'(a_ok), 32'd0);
      chk("midrst_len_err", 32'(a_len), 32'd0);
      chk("midrst_byte_count", 32'(a_cnt), 32'd0);
      @(posedge clock);
      #1;
      lst[8] = 1'b1;
      e.crc = 16'h29B1; e.chk_crc = 1'b1; e.ok = 1'b0; e.len = 1'b0; e.cnt = 9; e.lat = 83;
      exp_q.push_back(e);
      acc_cnt = 0;
      send_frame(9, 1'b0, 0, 1'b0);
      wait_done();
      chk("post_rst_accepted", 32'(acc_cnt), 32'd9);
      chk("post_rst_crc_hold", 32'(a_crc), 32'h29B1);

      repeat (3) @(posedge clock);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound in case a wait loop is broken.
   initial begin
      #5000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
